// File: rtl/debug_panel.sv
// Front-panel debug controller: run/halt/single-step sequencing, debounced step
// button, snapshot capture on halt and a scanned register/PC display mux.
module debug_panel #(
    parameter int NBITS    = 8,
    parameter int NREGS    = 32,
    parameter int SCAN_DIV = 4,
    parameter int DEB      = 3,
    localparam int IW      = $clog2(NREGS + 1)
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             scan_auto,
    input  logic [NBITS-1:0] regs_in [0:NREGS-1],
    input  logic [NBITS-1:0] pc_in,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [IW-1:0]    sel_idx,
    output logic [NBITS-1:0] sel_val,
    output logic             snap_valid
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    state_t                         st;
    logic                           sync1;
    logic                           sync2;
    logic                           deb_lvl;
    logic                           deb_dly;
    logic [DW-1:0]                  deb_cnt;
    logic                           step_pressed;
    logic                           capture;
    logic [PW-1:0]                  presc;
    logic [NREGS-1:0][NBITS-1:0]    snap_regs;
    logic [NBITS-1:0]               snap_pc;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return (idx == IW'(NREGS)) ? '0 : idx + IW'(1);
    endfunction

    // Button conditioning: the level only flips after DEB consecutive disagreeing samples.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_lvl <= 1'b0;
            deb_dly <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1   <= step_btn;
            sync2   <= sync1;
            deb_dly <= deb_lvl;
            if (sync2 != deb_lvl) begin
                if (deb_cnt == DW'(DEB - 1)) begin
                    deb_lvl <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign step_pressed = deb_lvl & ~deb_dly;

    // Any edge leaving RUN or STEP lands in HALT, so that is exactly when to capture.
    assign capture = (st == ST_STEP) || ((st == ST_RUN) && !run_sw);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            st         <= ST_HALT;
            snap_valid <= 1'b0;
            snap_regs  <= '0;
            snap_pc    <= '0;
        end else begin
            case (st)
                ST_HALT: begin
                    if (run_sw) begin
                        st         <= ST_RUN;
                        snap_valid <= 1'b0;
                    end else if (step_pressed) begin
                        st <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!run_sw) st <= ST_HALT;
                end
                default: st <= ST_HALT;
            endcase
            if (capture) begin
                for (int i = 0; i < NREGS; i++) snap_regs[i] <= regs_in[i];
                snap_pc    <= pc_in;
                snap_valid <= 1'b1;
            end
        end
    end

    assign state  = st;
    assign cpu_en = (st != ST_HALT);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            sel_idx <= '0;
        end else if (scan_auto) begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc   <= '0;
                sel_idx <= idx_inc(sel_idx);
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            presc <= '0;
            if ((st == ST_HALT) && step_pressed && !run_sw) sel_idx <= idx_inc(sel_idx);
        end
    end

    // Live data while running, frozen snapshot otherwise; index NREGS selects the PC.
    always_comb begin
        sel_val = (st == ST_RUN) ? pc_in : snap_pc;
        for (int i = 0; i < NREGS; i++) begin
            if (sel_idx == IW'(i)) sel_val = (st == ST_RUN) ? regs_in[i] : snap_regs[i];
        end
    end

endmodule

// File: tb/tb_debug_panel.sv
// Directed bench for debug_panel: debounce, step, run/halt snapshot, scan and reset abort.
module tb_debug_panel;

    logic       clk_2 = 1'b0;
    logic       reset_n;
    logic       run_sw;
    logic       step_btn;
    logic       scan_auto;
    logic [7:0] regs [0:31];
    logic [7:0] pc_in;
    logic       cpu_en;
    logic [1:0] state;
    logic [5:0] sel_idx;
    logic [7:0] sel_val;
    logic       snap_valid;

    int total = 0;
    int bad   = 0;
    int en_cnt;

    debug_panel dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .scan_auto (scan_auto),
        .regs_in   (regs),
        .pc_in     (pc_in),
        .cpu_en    (cpu_en),
        .state     (state),
        .sel_idx   (sel_idx),
        .sel_val   (sel_val),
        .snap_valid(snap_valid)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic tick_mon(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_2);
            #1;
            if (cpu_en) en_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 8'(i * 3 + 1);
        pc_in     = 8'hC3;
        run_sw    = 1'b0;
        step_btn  = 1'b0;
        scan_auto = 1'b0;
        reset_n   = 1'b0;
        tick(3);
        check("rst_state", 32'(state), 32'h1);
        check("rst_cpu_en", 32'(cpu_en), 32'h0);
        check("rst_sel_idx", 32'(sel_idx), 32'h0);
        check("rst_snap_valid", 32'(snap_valid), 32'h0);
        check("rst_sel_val", 32'(sel_val), 32'h0);
        reset_n = 1'b1;
        tick(2);
        check("post_rst_state", 32'(state), 32'h1);

        // 2-cycle glitch must be rejected
        step_btn = 1'b1;
        en_cnt   = 0;
        tick_mon(2);
        step_btn = 1'b0;
        tick_mon(10);
        check("glitch_en_cnt", 32'(en_cnt), 32'h0);
        check("glitch_state", 32'(state), 32'h1);

        // long press gives exactly one enabled cycle and a capture
        step_btn = 1'b1;
        en_cnt   = 0;
        tick_mon(10);
        check("step_en_cnt", 32'(en_cnt), 32'h1);
        check("step_state", 32'(state), 32'h1);
        check("step_snap_valid", 32'(snap_valid), 32'h1);
        check("step_idx_inc", 32'(sel_idx), 32'h1);
        check("step_snap_val", 32'(sel_val), 32'h4);
        regs[1] = 8'h77;
        #1;
        check("step_snap_frozen", 32'(sel_val), 32'h4);
        step_btn = 1'b0;
        en_cnt   = 0;
        tick_mon(8);
        check("release_en_cnt", 32'(en_cnt), 32'h0);

        // auto scan from index 1 to 5
        scan_auto = 1'b1;
        tick(16);
        scan_auto = 1'b0;
        check("scan_to5", 32'(sel_idx), 32'h5);
        tick(3);
        check("scan_hold", 32'(sel_idx), 32'h5);

        // run then halt with 0x5A at the halting edge
        regs[5] = 8'h5A;
        run_sw  = 1'b1;
        tick(1);
        check("run_state", 32'(state), 32'h0);
        check("run_cpu_en", 32'(cpu_en), 32'h1);
        check("run_snap_valid", 32'(snap_valid), 32'h0);
        check("run_live_5a", 32'(sel_val), 32'h5A);
        regs[5] = 8'h33;
        #1;
        check("run_live_33", 32'(sel_val), 32'h33);
        regs[5] = 8'h5A;
        run_sw  = 1'b0;
        tick(1);
        check("halt_state", 32'(state), 32'h1);
        check("halt_cpu_en", 32'(cpu_en), 32'h0);
        check("halt_snap_valid", 32'(snap_valid), 32'h1);
        regs[5] = 8'hFF;
        #1;
        check("halt_snap_5a", 32'(sel_val), 32'h5A);

        // run_sw wins over a coincident step pulse
        step_btn = 1'b1;
        tick(5);
        run_sw = 1'b1;
        tick(1);
        check("prio_state", 32'(state), 32'h0);
        check("prio_idx", 32'(sel_idx), 32'h5);
        step_btn = 1'b0;
        tick(8);
        check("prio_still_run", 32'(state), 32'h0);
        run_sw = 1'b0;
        tick(1);
        check("prio_halt_val", 32'(sel_val), 32'hFF);

        // reset during STEP aborts it
        step_btn = 1'b1;
        tick(6);
        check("mid_step_state", 32'(state), 32'h2);
        check("mid_step_en", 32'(cpu_en), 32'h1);
        reset_n  = 1'b0;
        step_btn = 1'b0;
        #1;
        check("abort_cpu_en", 32'(cpu_en), 32'h0);
        check("abort_state", 32'(state), 32'h1);
        check("abort_snap_valid", 32'(snap_valid), 32'h0);
        check("abort_sel_idx", 32'(sel_idx), 32'h0);
        check("abort_sel_val", 32'(sel_val), 32'h0);
        tick(2);
        reset_n = 1'b1;
        en_cnt  = 0;
        tick_mon(10);
        check("abort_no_pulse", 32'(en_cnt), 32'h0);

        // reset during debounce aborts it
        step_btn = 1'b1;
        tick(3);
        reset_n  = 1'b0;
        step_btn = 1'b0;
        tick(1);
        reset_n = 1'b1;
        en_cnt  = 0;
        tick_mon(10);
        check("deb_abort_en", 32'(en_cnt), 32'h0);
        check("deb_abort_state", 32'(state), 32'h1);

        // capture PC, then scan the full index range including the wrap
        run_sw = 1'b1;
        tick(1);
        run_sw = 1'b0;
        tick(1);
        check("cap_snap_valid", 32'(snap_valid), 32'h1);
        scan_auto = 1'b1;
        tick(3);
        check("scan_idx0", 32'(sel_idx), 32'h0);
        tick(1);
        check("scan_idx1", 32'(sel_idx), 32'h1);
        tick(120);
        check("scan_idx31", 32'(sel_idx), 32'd31);
        tick(3);
        check("scan_idx31_hold", 32'(sel_idx), 32'd31);
        tick(1);
        check("scan_idx32", 32'(sel_idx), 32'd32);
        check("scan_pc_val", 32'(sel_val), 32'hC3);
        tick(4);
        check("scan_wrap0", 32'(sel_idx), 32'h0);
        check("scan_reg0_val", 32'(sel_val), 32'h1);
        scan_auto = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
